// File: rtl/lc3_ctrl_pkg.sv
// ============================================================================
// Module  : lc3_ctrl_pkg
// Brief   : Shared opcodes, state encodings and opcode classifiers for the
//           LC-3 pipeline controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lc3_ctrl_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_BR  = 4'b0000;
    localparam opcode_t OP_ADD = 4'b0001;
    localparam opcode_t OP_LD  = 4'b0010;
    localparam opcode_t OP_ST  = 4'b0011;
    localparam opcode_t OP_AND = 4'b0101;
    localparam opcode_t OP_LDR = 4'b0110;
    localparam opcode_t OP_STR = 4'b0111;
    localparam opcode_t OP_NOT = 4'b1001;
    localparam opcode_t OP_LDI = 4'b1010;
    localparam opcode_t OP_STI = 4'b1011;
    localparam opcode_t OP_JMP = 4'b1100;

    typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, MEM = 2'd2, CTRL = 2'd3} ctrl_state_e;
    typedef enum logic [1:0] {MS_READ = 2'd0, MS_IND = 2'd1, MS_WRITE = 2'd2, MS_IDLE = 2'd3} mem_state_e;

    function automatic logic is_load(input opcode_t op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_mem_op(input opcode_t op);
        return is_load(op) || (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input opcode_t op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    function automatic logic is_alu(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_pipe_ctrl_mem_seq.sv
// ============================================================================
// Module  : lc3_mem_seq
// Brief   : Data-memory access sub-FSM; walks mem_state for one load/store and
//           flags the edge on which the access completes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc3_mem_seq
    import lc3_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  opcode_t    op,
    input  logic       complete_data,
    output logic [1:0] mem_state,
    output logic       done,
    output logic       load_done
);

    mem_state_e ms_q, ms_d;
    opcode_t    op_q, op_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            ms_q <= MS_IDLE;
            op_q <= OP_BR;
        end else begin
            ms_q <= ms_d;
            op_q <= op_d;
        end
    end

    always_comb begin
        ms_d = ms_q;
        op_d = op_q;
        case (ms_q)
            MS_IDLE: begin
                // complete_data is deliberately ignored while idle
                if (start) begin
                    op_d = op;
                    if ((op == OP_LDI) || (op == OP_STI)) ms_d = MS_IND;
                    else if (is_load(op))                 ms_d = MS_READ;
                    else                                  ms_d = MS_WRITE;
                end
            end
            MS_IND: begin
                if (complete_data) ms_d = (op_q == OP_LDI) ? MS_READ : MS_WRITE;
            end
            default: begin
                if (complete_data) ms_d = MS_IDLE;
            end
        endcase
    end

    assign mem_state = ms_q;
    assign done      = ((ms_q == MS_READ) || (ms_q == MS_WRITE)) && complete_data;
    assign load_done = (ms_q == MS_READ) && complete_data;

endmodule

`default_nettype wire

// File: rtl/lc3_pipe_ctrl.sv
// ============================================================================
// Module  : lc3_pipe_ctrl
// Brief   : LC-3 pipeline sequencer: stage enables, memory stalls, branch
//           bubbles. Optional operand forwarding under macro LC3_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc3_pipe_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int CTRL_BUBBLES = 2,
    parameter int OPC_W        = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2
);

    localparam logic [1:0] LAST_CNT = 2'(CTRL_BUBBLES);

    ctrl_state_e state_q, state_d;
    logic [1:0]  fc_q, fc_d;
    logic [1:0]  ctrl_cnt_q, ctrl_cnt_d;
    logic        mem_ret_q, mem_ret_d;
    logic        upd_q, upd_d, fetch_q, fetch_d, dec_q, dec_d;
    logic        exe_q, exe_d, wb_q, wb_d, br_q, br_d;
    logic [3:0]  byp_q, byp_d;

    opcode_t     w_op_dec, w_op_exe;
    logic        w_mem_hit, w_ctrl_hit, w_wb_rule, w_mem_start;
    logic        w_seq_done, w_seq_load_done;
    logic [3:0]  w_byp;
    logic        w_unused_bits;

    assign w_op_dec      = IR[15 -: OPC_W];
    assign w_op_exe      = IR_Exec[15 -: OPC_W];
    assign w_unused_bits = ^{IR[11:0], IR_Exec[8:0]};

    assign w_mem_hit  = is_mem_op(w_op_exe) && exe_q;
    // After a memory stall decode was frozen, so a waiting BR/JMP still counts
    assign w_ctrl_hit = is_ctrl(w_op_dec) && (dec_q || mem_ret_q);
    assign w_wb_rule  = exe_q && !is_mem_op(w_op_exe) && !is_ctrl(w_op_exe);

`ifdef LC3_BYPASS_EN
    always_comb begin
        w_byp = 4'b0000;
        if (is_alu(w_op_exe)) begin
            w_byp[3] = (IR_Exec[11:9] == IR[8:6]);
            w_byp[2] = !IR[5] && (IR_Exec[11:9] == IR[2:0]);
        end
        if (is_load(w_op_exe)) begin
            w_byp[1] = (IR_Exec[11:9] == IR[8:6]);
            w_byp[0] = !IR[5] && (IR_Exec[11:9] == IR[2:0]);
        end
    end
`else
    assign w_byp = 4'b0000;
`endif

    lc3_mem_seq u_mem_seq (
        .clock         (clock),
        .reset         (reset),
        .start         (w_mem_start),
        .op            (w_op_exe),
        .complete_data (complete_data),
        .mem_state     (mem_state),
        .done          (w_seq_done),
        .load_done     (w_seq_load_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FILL;
            fc_q       <= 2'd0;
            ctrl_cnt_q <= 2'd0;
            mem_ret_q  <= 1'b0;
            upd_q      <= 1'b0;
            fetch_q    <= 1'b0;
            dec_q      <= 1'b0;
            exe_q      <= 1'b0;
            wb_q       <= 1'b0;
            br_q       <= 1'b0;
            byp_q      <= 4'b0000;
        end else begin
            state_q    <= state_d;
            fc_q       <= fc_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            mem_ret_q  <= mem_ret_d;
            upd_q      <= upd_d;
            fetch_q    <= fetch_d;
            dec_q      <= dec_d;
            exe_q      <= exe_d;
            wb_q       <= wb_d;
            br_q       <= br_d;
            byp_q      <= byp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fc_d        = fc_q;
        ctrl_cnt_d  = ctrl_cnt_q;
        mem_ret_d   = mem_ret_q;
        w_mem_start = 1'b0;
        case (state_q)
            FILL: begin
                fc_d = fc_q + 2'd1;
                if (fc_q == 2'd3) state_d = RUN;
            end
            RUN: begin
                if (!complete_instr) begin
                    state_d = RUN;
                end else if (w_mem_hit) begin
                    state_d     = MEM;
                    w_mem_start = 1'b1;
                    mem_ret_d   = 1'b0;
                end else if (w_ctrl_hit) begin
                    state_d    = CTRL;
                    ctrl_cnt_d = 2'd0;
                    mem_ret_d  = 1'b0;
                end else begin
                    mem_ret_d = 1'b0;
                end
            end
            MEM: begin
                if (w_seq_done) begin
                    state_d   = RUN;
                    mem_ret_d = 1'b1;
                end
            end
            default: begin
                if (ctrl_cnt_q == LAST_CNT) state_d = RUN;
                else                        ctrl_cnt_d = ctrl_cnt_q + 2'd1;
            end
        endcase
    end

    always_comb begin
        upd_d   = 1'b0;
        fetch_d = 1'b0;
        dec_d   = 1'b0;
        exe_d   = 1'b0;
        wb_d    = 1'b0;
        br_d    = 1'b0;
        byp_d   = 4'b0000;
        case (state_q)
            FILL: begin
                upd_d   = 1'b1;
                fetch_d = 1'b1;
                dec_d   = (fc_q != 2'd0);
                exe_d   = fc_q[1];
                wb_d    = (fc_q == 2'd3);
            end
            RUN: begin
                if (complete_instr && !w_mem_hit) begin
                    wb_d  = w_wb_rule;
                    exe_d = 1'b1;
                    if (!w_ctrl_hit) begin
                        upd_d   = 1'b1;
                        fetch_d = 1'b1;
                        dec_d   = 1'b1;
                        byp_d   = w_byp;
                    end
                end
            end
            MEM: begin
                wb_d = w_seq_load_done;
            end
            default: begin
                if (ctrl_cnt_q == LAST_CNT) begin
                    upd_d   = 1'b1;
                    fetch_d = 1'b1;
                    dec_d   = 1'b1;
                    exe_d   = 1'b1;
                    wb_d    = w_wb_rule;
                end else begin
                    wb_d = w_wb_rule;
                    if (ctrl_cnt_q == 2'd0) begin
                        // The branch has reached execute: resolve it and load PC
                        upd_d = 1'b1;
                        br_d  = (w_op_exe == OP_JMP) ? 1'b1 : |(IR_Exec[11:9] & psr);
                    end
                end
            end
        endcase
    end

    assign enable_updatePC  = upd_q;
    assign enable_fetch     = fetch_q;
    assign enable_decode    = dec_q;
    assign enable_execute   = exe_q;
    assign enable_writeback = wb_q;
    assign br_taken         = br_q;
    assign bypass_alu_1     = byp_q[3];
    assign bypass_alu_2     = byp_q[2];
    assign bypass_mem_1     = byp_q[1];
    assign bypass_mem_2     = byp_q[0];

endmodule

`default_nettype wire

// File: tb/tb_lc3_pipe_ctrl.sv
// ============================================================================
// Module  : tb_lc3_pipe_ctrl
// Brief   : Directed self-checking bench for lc3_pipe_ctrl (CTRL_BUBBLES=2);
//           bypass expectations follow macro LC3_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lc3_pipe_ctrl;

    logic        clock = 1'b0;
    logic        reset, complete_instr, complete_data;
    logic [15:0] IR, IR_Exec;
    logic [2:0]  psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [4:0]  en;
    logic [3:0]  byp;
    int          total = 0;
    int          bad   = 0;

    localparam logic [15:0] BG_IR   = 16'h1505;
    localparam logic [15:0] BG_EXEC = 16'h1260;

    logic [1:0] ldi_ms [0:6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3};
    logic       ldi_cd [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clock = ~clock;

    assign en  = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
    assign byp = {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};

    lc3_pipe_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .mem_state        (mem_state),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic branch_check(input string tag, input logic [15:0] br_ir,
                                input logic [2:0] flags, input logic exp_taken);
        IR  = br_ir;
        psr = flags;
        tick(); chk({tag, "_c1_en"}, 8'(en), 8'b00011); chk({tag, "_c1_br"}, 8'(br_taken), 8'd0);
        IR_Exec = br_ir;
        tick(); chk({tag, "_c2_en"}, 8'(en), 8'b10000); chk({tag, "_c2_br"}, 8'(br_taken), 8'(exp_taken));
        tick(); chk({tag, "_c3_en"}, 8'(en), 8'b00000); chk({tag, "_c3_br"}, 8'(br_taken), 8'd0);
        IR = BG_IR; IR_Exec = BG_EXEC;
        tick(); chk({tag, "_c4_en"}, 8'(en), 8'b11110);
        tick(); chk({tag, "_c5_en"}, 8'(en), 8'b11111);
    endtask

    initial begin
        reset = 1'b1; complete_instr = 1'b1; complete_data = 1'b0;
        IR = BG_IR; IR_Exec = BG_EXEC; psr = 3'b000;
        tick(); tick();
        chk("rst_en", 8'(en), 8'd0);
        chk("rst_br", 8'(br_taken), 8'd0);
        chk("rst_ms", 8'(mem_state), 8'd3);
        chk("rst_byp", 8'(byp), 8'd0);

        reset = 1'b0;
        tick(); chk("fill1", 8'(en), 8'b11000);
        tick(); chk("fill2", 8'(en), 8'b11100);
        tick(); chk("fill3", 8'(en), 8'b11110);
        tick(); chk("fill4", 8'(en), 8'b11111);
        tick(); chk("run1",  8'(en), 8'b11111);

        // LDI R3 with two-cycle data waits in each phase
        IR_Exec = 16'hA600;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("ldi_ms%0d", i), 8'(mem_state), 8'(ldi_ms[i]));
            chk($sformatf("ldi_en%0d", i), 8'(en), (i == 6) ? 8'b00001 : 8'b00000);
            complete_data = ldi_cd[i];
        end
        IR_Exec = BG_EXEC;
        tick(); chk("ldi_ret1", 8'(en), 8'b11110);
        tick(); chk("ldi_ret2", 8'(en), 8'b11111);

        branch_check("br_tk", 16'h0400, 3'b010, 1'b1);
        branch_check("br_nt", 16'h0400, 3'b100, 1'b0);

        // STI in execute with JMP R2 waiting in decode
        IR_Exec = 16'hB600; IR = 16'hC080;
        tick(); chk("sti_ms1", 8'(mem_state), 8'd1); chk("sti_en1", 8'(en), 8'b00000);
        complete_data = 1'b1;
        tick(); chk("sti_ms2", 8'(mem_state), 8'd2); chk("sti_en2", 8'(en), 8'b00000);
        tick(); chk("sti_ms3", 8'(mem_state), 8'd3); chk("sti_en3", 8'(en), 8'b00000);
        complete_data = 1'b0;
        tick(); chk("jmp_c1_en", 8'(en), 8'b00010);
        IR_Exec = 16'hC080;
        tick(); chk("jmp_c2_en", 8'(en), 8'b10000); chk("jmp_c2_br", 8'(br_taken), 8'd1);
        tick(); chk("jmp_c3_en", 8'(en), 8'b00000); chk("jmp_c3_br", 8'(br_taken), 8'd0);
        IR = BG_IR; IR_Exec = BG_EXEC;
        tick(); chk("jmp_c4_en", 8'(en), 8'b11110);

        // LD then reset while the read is outstanding
        IR_Exec = 16'h2600;
        tick(); chk("ld_ms", 8'(mem_state), 8'd0); chk("ld_en", 8'(en), 8'b00000);
        reset = 1'b1;
        tick(); chk("mrst_en", 8'(en), 8'd0); chk("mrst_ms", 8'(mem_state), 8'd3);
        chk("mrst_br", 8'(br_taken), 8'd0);
        reset = 1'b0; IR_Exec = BG_EXEC;
        tick(); chk("refill1", 8'(en), 8'b11000);
        tick(); tick(); tick(); chk("refill4", 8'(en), 8'b11111);

        complete_instr = 1'b0;
        tick(); chk("stall_en", 8'(en), 8'b00000);
        complete_instr = 1'b1;
        tick(); chk("unstall_en", 8'(en), 8'b11110);

        // ADD R3 in execute, ADD R1,R3,R3 in decode; data strobe while idle
        IR_Exec = 16'h1600; IR = 16'h12C3; complete_data = 1'b1;
        tick();
`ifdef LC3_BYPASS_EN
        chk("byp_add", 8'(byp), 8'b1100);
`else
        chk("byp_add", 8'(byp), 8'b0000);
`endif
        chk("idle_ms", 8'(mem_state), 8'd3);
        chk("byp_en", 8'(en), 8'b11111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lc3_pipe_ctrl.md
Name: lc3_pipe_ctrl

Overview:
- Central sequencer for the LC-3 pipeline.
- Drives the stage enables that gate fetch, decode (the decode_out producer), execute and writeback.
- Inserts stalls for data-memory accesses and bubbles for control-flow instructions.
- Sits beside the datapath: consumes the decode-stage IR, the execute-stage IR, PSR and memory-complete flags.

Parameters:
- CTRL_BUBBLES, 2, cycles fetch/decode are held off after a BR/JMP reaches decode (legal 1..3)
- OPC_W, 4, opcode field width (IR[15:12])

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- complete_instr  in  1  instruction memory has returned IMem_dout
- complete_data  in  1  data memory access finished this cycle
- IR  in  16  instruction in decode stage
- IR_Exec  in  16  instruction in execute stage
- psr  in  3  NZP condition flags
- enable_updatePC  out  1  PC register load enable
- enable_fetch  out  1  fetch stage enable
- enable_decode  out  1  decode stage enable
- enable_execute  out  1  execute stage enable
- enable_writeback  out  1  register-file write enable
- br_taken  out  1  select branch/jump target for PC
- mem_state  out  2  0=read, 1=indirect read, 2=write, 3=idle
- bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  out  1 each  operand forwarding selects

Behaviour:
- Reset state:
  - All enables 0, br_taken 0, mem_state 3, bypass_* 0.
  - State FILL, fill counter fc=0.
- All outputs are registered.
- Opcodes: BR=0000, JMP=1100, LD=0010, LDR=0110, LDI=1010, ST=0011, STR=0111, STI=1011.
- FILL state, fc counts 0..3:
  - enable_updatePC and enable_fetch = 1.
  - enable_decode = fc>=1; enable_execute = fc>=2; enable_writeback = fc>=3.
  - fc==3 -> RUN.
- RUN state:
  - All enables 1 by default.
  - enable_writeback = previous-cycle enable_execute AND IR_Exec opcode not in {BR, JMP, ST, STR, STI, LD, LDR, LDI}.
- Priority in RUN, highest first:
  1. complete_instr=0: all enables 0, state held.
  2. Memory opcode in IR_Exec while enable_execute=1 -> memory sequence.
  3. BR/JMP in IR while enable_decode=1 -> CTRL.
- Memory sequence:
  - Next cycle: enables updatePC/fetch/decode/execute = 0.
  - mem_state walks: LD/LDR: 0 -> 3; ST/STR: 2 -> 3; LDI: 1 -> 0 -> 3; STI: 1 -> 2 -> 3.
  - Each non-idle mem_state advances only on a cycle with complete_data=1; otherwise it holds indefinitely.
  - Loads: enable_writeback=1 for exactly one cycle, the cycle mem_state returns to 3.
  - Then back to RUN with all enables 1.
- CTRL state:
  - Lasts CTRL_BUBBLES+1 cycles.
  - Cycle 1: enable_fetch/decode/updatePC = 0, enable_execute = 1.
  - Cycle 2: br_taken = (IR_Exec[11:9] & psr) != 0 for BR, 1 for JMP; enable_updatePC = 1 (pulse); fetch/decode = 0.
  - Remaining bubble cycles hold fetch/decode at 0.
  - Then RUN.
  - br_taken returns to 0 the cycle after the pulse.
  - Not-taken BR still pulses enable_updatePC (PC+1 path).
- Simultaneous events:
  - A memory op in execute and BR in decode in the same cycle: the memory sequence runs first, then CTRL is entered on return to RUN (IR is unchanged because decode was frozen).
  - complete_data=1 while mem_state=3 is ignored.
- Reset asserted mid-sequence (mem or CTRL): next cycle all outputs take their reset values; state FILL, fc=0.

Optional Feature:
- Macro LC3_BYPASS_EN.
- Defined:
  - bypass_alu_1 = 1 when IR_Exec is an ALU op (ADD/AND/NOT) AND IR_Exec[11:9] == IR[8:6].
  - bypass_alu_2 = same compare against IR[2:0], only when IR[5]=0.
  - bypass_mem_1/2 = same compares for an LD/LDR/LDI destination.
  - All are registered alongside enable_execute and forced to 0 during stall/CTRL cycles.
- Undefined: the four bypass outputs are tied 0 and the compare logic is absent; ports remain.

Decomposition:
- Shared package lc3_ctrl_pkg holds:
  - opcode localparams;
  - state enum {FILL, RUN, MEM, CTRL};
  - mem_state encodings {MS_READ=0, MS_IND=1, MS_WRITE=2, MS_IDLE=3};
  - is_mem_op/is_load functions.
- One natural sub-module: lc3_mem_seq, the memory-access sub-FSM producing mem_state and the load writeback pulse.

Test Plan:
- Reset released, complete_instr=1, NOPs -> fetch=1 cycle1, decode cycle2, execute cycle3, writeback cycle4, then steady 1s.
- LDI in IR_Exec, complete_data low 2 cycles in each phase -> mem_state 1,1,1,0,0,0,3; enables 0 throughout; single enable_writeback pulse on return to 3.
- BR with IR_Exec[11:9]=010, psr=010 -> br_taken=1 and updatePC pulse in CTRL cycle 2; fetch off for CTRL_BUBBLES+1 cycles. Repeat with psr=100 -> br_taken=0, updatePC still pulses.
- STI in execute plus JMP in decode simultaneously -> mem_state 1,2,3 and no writeback, then CTRL sequence with br_taken=1.
- Reset asserted during mem_state=0 -> next cycle all outputs at reset values, FILL restarts.
- LC3_BYPASS_EN defined, ADD R3 in execute, ADD R1,R3,R3 in decode -> bypass_alu_1=1 and bypass_alu_2=1; macro undefined -> both 0.
